// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding (legacy-compatible constants plus an enum
// built on them) and the helper that sizes the bit counter from WIDTH.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // Counter must hold 0..width-1; a 1-bit counter is kept even for width 1
    // so the register never collapses to zero bits.
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result channel bundle for serial_subtractor.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Ports (signals):
//   in_valid, in_ready, lhs[WIDTH], rhs[WIDTH], bin   operand channel
//   out_valid, out_ready, diff[WIDTH], bout            result channel
// master = requester (drives operands, takes results), slave = subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             bin;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, bin, lhs, rhs, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, bin, lhs, rhs, out_ready,
        output in_ready, out_valid, diff, bout
    );

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bi (mod 2), bo = borrow out.
// Latency: combinational.
// Backpressure: none.
//
// Ports: a (minuend bit), b (subtrahend bit), bi (borrow in),
//        d (difference bit), bo (borrow out).
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    // Borrow when b beats a outright, or when a == b and a borrow is pending.
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (lhs - rhs - bin) mod 2^WIDTH, bout = borrow.
// Latency: result valid WIDTH cycles after the accept edge; WIDTH+2 cycles per op at best.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
//
// Ports: clk, reset (synchronous, active-high), bus (serial_subtractor_if.slave).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_d;
    logic             bit_bo;

    full_subtractor_bit u_bit (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (brw_q),
        .d  (bit_d),
        .bo (bit_bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.lhs;
                    b_d     = bus.rhs;
                    brw_d   = bus.bin;
                    diff_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                // New bit enters at the MSB; after WIDTH shifts the LSB-first
                // stream lands in natural bit order. The extra bit of the
                // concatenation keeps this legal for WIDTH = 1.
                diff_d = WIDTH'({bit_d, diff_q} >> 1);
                brw_d  = bit_bo;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs come straight from the state register: no
    // combinational path from in_valid or out_ready.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = brw_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 4, 2 and 1, plus the one-bit cell.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low while results are pending.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(4)) s4 ();
    serial_subtractor_if #(.WIDTH(2)) s2 ();
    serial_subtractor_if #(.WIDTH(1)) s1 ();

    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(s4.slave));
    serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(s2.slave));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(s1.slave));

    logic fa, fb, fbi, fd, fbo;
    full_subtractor_bit u_cell (.a(fa), .b(fb), .bi(fbi), .d(fd), .bo(fbo));

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         w;
        logic [3:0] lhs;
        logic [3:0] rhs;
        logic       bin;
        logic [3:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drv(input int w, input logic v, input logic [3:0] l,
                       input logic [3:0] r, input logic b, input logic ordy);
        case (w)
            4: begin
                s4.in_valid = v; s4.lhs = l; s4.rhs = r; s4.bin = b; s4.out_ready = ordy;
            end
            2: begin
                s2.in_valid = v; s2.lhs = l[1:0]; s2.rhs = r[1:0]; s2.bin = b; s2.out_ready = ordy;
            end
            default: begin
                s1.in_valid = v; s1.lhs = l[0:0]; s1.rhs = r[0:0]; s1.bin = b; s1.out_ready = ordy;
            end
        endcase
    endtask

    function automatic logic [3:0] get_diff(input int w);
        case (w)
            4:       return s4.diff;
            2:       return {2'b00, s2.diff};
            default: return {3'b000, s1.diff};
        endcase
    endfunction

    function automatic logic get_bout(input int w);
        case (w)
            4:       return s4.bout;
            2:       return s2.bout;
            default: return s1.bout;
        endcase
    endfunction

    function automatic logic get_ovld(input int w);
        case (w)
            4:       return s4.out_valid;
            2:       return s2.out_valid;
            default: return s1.out_valid;
        endcase
    endfunction

    function automatic logic get_irdy(input int w);
        case (w)
            4:       return s4.in_ready;
            2:       return s2.in_ready;
            default: return s1.in_ready;
        endcase
    endfunction

    // Full handshake for one operation: accept, scramble operand inputs,
    // measure latency, check result, then drain with out_ready.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(posedge clk); #1;
        drv(v.w, 1'b1, v.lhs, v.rhs, v.bin, 1'b0);
        check($sformatf("%s in_ready_before", tag), get_irdy(v.w), 1);
        @(posedge clk); #1;                       // accept edge E0
        drv(v.w, 1'b0, ~v.lhs, ~v.rhs, ~v.bin, 1'b0);
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (get_ovld(v.w)) lat = i;
        end
        check($sformatf("%s latency", tag), lat, v.w);
        check($sformatf("%s diff", tag), get_diff(v.w), v.exp_diff);
        check($sformatf("%s bout", tag), get_bout(v.w), v.exp_bout);
        drv(v.w, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check($sformatf("%s out_valid_after_drain", tag), get_ovld(v.w), 0);
        check($sformatf("%s in_ready_after_drain", tag), get_irdy(v.w), 1);
        drv(v.w, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  ws[3];
        int  lat;
        bit  seen;
        int  dv;

        ws = '{4, 2, 1};

        // Hand-computed vectors: {width, lhs, rhs, bin, diff, bout}
        vecs.push_back('{4, 4'd9,  4'd3,  1'b0, 4'd6,  1'b0});
        vecs.push_back('{4, 4'd3,  4'd9,  1'b1, 4'd9,  1'b1});
        vecs.push_back('{4, 4'd0,  4'd15, 1'b1, 4'd0,  1'b1});
        vecs.push_back('{4, 4'd15, 4'd15, 1'b0, 4'd0,  1'b0});
        vecs.push_back('{4, 4'd15, 4'd0,  1'b1, 4'd14, 1'b0});
        vecs.push_back('{4, 4'd0,  4'd0,  1'b1, 4'd15, 1'b1});
        vecs.push_back('{4, 4'd8,  4'd8,  1'b1, 4'd15, 1'b1});
        vecs.push_back('{4, 4'd10, 4'd5,  1'b0, 4'd5,  1'b0});
        vecs.push_back('{4, 4'd12, 4'd15, 1'b0, 4'd13, 1'b1});
        vecs.push_back('{2, 4'd1,  4'd3,  1'b1, 4'd1,  1'b1});
        vecs.push_back('{2, 4'd3,  4'd1,  1'b0, 4'd2,  1'b0});
        vecs.push_back('{2, 4'd2,  4'd2,  1'b1, 4'd3,  1'b1});
        vecs.push_back('{1, 4'd0,  4'd1,  1'b0, 4'd1,  1'b1});
        vecs.push_back('{1, 4'd1,  4'd0,  1'b1, 4'd0,  1'b0});
        vecs.push_back('{1, 4'd0,  4'd0,  1'b1, 4'd1,  1'b1});

        // Reset held two cycles with a request pending: nothing accepted.
        reset = 1'b1;
        drv(4, 1'b1, 4'd9, 4'd3, 1'b0, 1'b0);
        drv(2, 1'b1, 4'd1, 4'd3, 1'b1, 1'b0);
        drv(1, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        foreach (ws[k]) begin
            check($sformatf("rst_w%0d in_ready", ws[k]), get_irdy(ws[k]), 1);
            check($sformatf("rst_w%0d out_valid", ws[k]), get_ovld(ws[k]), 0);
            check($sformatf("rst_w%0d diff", ws[k]), get_diff(ws[k]), 0);
            check($sformatf("rst_w%0d bout", ws[k]), get_bout(ws[k]), 0);
        end
        reset = 1'b0;
        foreach (ws[k]) drv(ws[k], 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_release in_ready", get_irdy(4), 1);

        // One-bit cell against integer arithmetic: a - b - bi = d - 2*bo.
        for (int k = 0; k < 8; k++) begin
            fa = k[2]; fb = k[1]; fbi = k[0];
            #1;
            dv = int'(fa) - int'(fb) - int'(fbi);
            check($sformatf("cell%0d d", k), fd, dv & 1);
            check($sformatf("cell%0d bo", k), fbo, (dv < 0) ? 1 : 0);
        end

        // Table-driven operations.
        foreach (vecs[k]) begin
            run_op(vecs[k], $sformatf("vec%0d_w%0d", k, vecs[k].w));
        end

        // Backpressure: result held 5 cycles, new requests ignored.
        @(posedge clk); #1;
        drv(4, 1'b1, 4'd5, 4'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        drv(4, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (get_ovld(4)) lat = i;
        end
        check("bp latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            drv(4, 1'b1, 4'(c + 1), 4'd0, 1'b1, 1'b0);
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", c), get_ovld(4), 1);
            check($sformatf("bp%0d diff", c), get_diff(4), 3);
            check($sformatf("bp%0d bout", c), get_bout(4), 0);
            check($sformatf("bp%0d in_ready", c), get_irdy(4), 0);
        end
        drv(4, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("bp_release out_valid", get_ovld(4), 0);
        check("bp_release in_ready", get_irdy(4), 1);
        drv(4, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("bp_idle_hold in_ready", get_irdy(4), 1);

        // Reset at cnt = 2 mid-RUN: operation discarded, no out_valid.
        drv(4, 1'b1, 4'd9, 4'd3, 1'b0, 1'b0);
        @(posedge clk); #1;                       // E0, cnt = 0
        drv(4, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        @(posedge clk); #1;                       // cnt = 1
        @(posedge clk); #1;                       // cnt = 2
        check("midrst running in_ready", get_irdy(4), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst in_ready", get_irdy(4), 1);
        check("midrst out_valid", get_ovld(4), 0);
        check("midrst diff", get_diff(4), 0);
        drv(4, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (get_ovld(4)) seen = 1'b1;
        end
        check("midrst no_out_valid", seen, 0);

        // Normal operation after the aborted one.
        run_op(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
